// File: rtl/pc_gen.sv
// Fetch PC generator: holds the architectural fetch PC, predicts the next PC
// from fetch predecode flags and a table of 2-bit saturating counters, and
// accepts redirects from execute and branch-outcome updates for the table.
module pc_gen #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          BHT_IDX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] inst,
    input  logic        is_jump,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_branch,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        bht_update_valid,
    input  logic [31:0] bht_update_pc,
    input  logic        bht_update_taken,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;

    logic [31:0]             pc_q, pc_d;
    logic [1:0]              bht_q [BHT_ENTRIES];
    logic [1:0]              bht_d [BHT_ENTRIES];
    logic [BHT_IDX_BITS-1:0] lookup_idx;
    logic [BHT_IDX_BITS-1:0] update_idx;
    logic [31:0]             j_imm;
    logic [31:0]             b_imm;
    logic [31:0]             pc_plus4;

    // Conditional branches are recognised as jumps that are neither JAL nor
    // JALR, so the separate branch flag and the opcode bits are redundant here.
    logic unused_ok;
    assign unused_ok = ^{is_branch, inst[6:0], redirect_pc[1:0],
                         bht_update_pc[31:BHT_IDX_BITS+2], bht_update_pc[1:0]};

    assign lookup_idx = pc_q[BHT_IDX_BITS+1:2];
    assign update_idx = bht_update_pc[BHT_IDX_BITS+1:2];

    assign j_imm    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

    assign pc = pc_q;

    // Prediction for the instruction currently at pc; JALR always falls
    // through and relies on execute to redirect.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        if (is_jump) begin
            if (is_jal) begin
                pred_taken  = 1'b1;
                pred_target = pc_q + j_imm;
            end else if (!is_jalr && bht_q[lookup_idx][1]) begin
                pred_taken  = 1'b1;
                pred_target = pc_q + b_imm;
            end
        end
    end

    // Next PC: redirect beats stall beats prediction; the PC stays word aligned.
    always_comb begin
        pc_d = pred_target;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
        pc_d[1:0] = 2'b00;
    end

    // Saturating counter update; lookup this cycle still reads bht_q.
    always_comb begin
        for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_d[i] = bht_q[i];
        end
        if (bht_update_valid) begin
            if (bht_update_taken) begin
                if (bht_q[update_idx] != 2'd3) begin
                    bht_d[update_idx] = bht_q[update_idx] + 2'd1;
                end
            end else begin
                if (bht_q[update_idx] != 2'd0) begin
                    bht_d[update_idx] = bht_q[update_idx] - 2'd1;
                end
            end
        end
    end

    // State registers; reset leaves every counter weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else begin
            pc_q <= pc_d;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= bht_d[i];
            end
        end
    end

endmodule
